// File: rtl/alu_pkg.sv
// Shared encodings for the ALU-control decoder and the sequential execute unit.
package alu_pkg;

  localparam int WIDTH_DEF = 16;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_ADD0 = 4'b0100;
  localparam logic [3:0] OP_ADD1 = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SUB0 = 4'b1100;
  localparam logic [3:0] OP_SUB1 = 4'b1101;

  localparam logic ST_IDLE_ENC  = 1'b0;
  localparam logic ST_SHIFT_ENC = 1'b1;

  typedef enum logic {
    ST_IDLE  = ST_IDLE_ENC,
    ST_SHIFT = ST_SHIFT_ENC
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle datapath: logic ops, add/sub with signed overflow, SLT, illegal decode.
// Shift codes pass A through so a shift by zero completes here.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             ovf_o,
  output logic             illegal_o
);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             sum_ovf;
  logic             lt;

  // SLT shares the subtractor; less-than corrects the sign bit by overflow.
  always_comb begin
    sub     = (op_i == OP_SUB0) || (op_i == OP_SUB1) || (op_i == OP_SLT);
    b_eff   = sub ? ~b_i : b_i;
    sum     = a_i + b_eff + {{(WIDTH-1){1'b0}}, sub};
    sum_ovf = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    lt      = sum[WIDTH-1] ^ sum_ovf;
  end

  always_comb begin
    res_o     = '0;
    ovf_o     = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      OP_AND:            res_o = a_i & b_i;
      OP_OR:             res_o = a_i | b_i;
      OP_XOR:            res_o = a_i ^ b_i;
      OP_ADD0, OP_ADD1,
      OP_SUB0, OP_SUB1: begin
        res_o = sum;
        ovf_o = sum_ovf;
      end
      OP_SLT:            res_o = {{(WIDTH-1){1'b0}}, lt};
      OP_SLL, OP_SRL:    res_o = a_i;
      default:           illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Sequential execute unit: one-cycle logic/arith ops, bit-serial shifts,
// Start/Busy/Done handshake and registered result with Zero/Overflow/Illegal.
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [3:0]       Operacioni,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             Illegal
);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;
  logic             srl_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;
  logic             ill_q;

  logic [WIDTH-1:0] c_res;
  logic             c_ovf;
  logic             c_ill;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op_i      (Operacioni),
    .a_i       (A),
    .b_i       (B),
    .res_o     (c_res),
    .ovf_o     (c_ovf),
    .illegal_o (c_ill)
  );

  assign sh_d = srl_q ? (sh_q >> 1) : (sh_q << 1);

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      srl_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            if (is_shift(Operacioni) && (B[3:0] != 4'd0)) begin
              sh_q    <= A;
              cnt_q   <= B[3:0];
              srl_q   <= (Operacioni == OP_SRL);
              busy_q  <= 1'b1;
              state_q <= ST_SHIFT;
            end else begin
              result_q <= c_res;
              zero_q   <= (c_res == '0);
              ovf_q    <= c_ovf;
              ill_q    <= c_ill;
              done_q   <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          sh_q  <= sh_d;
          cnt_q <= cnt_q - 4'd1;
          // Final step: publish the shifted value in the same edge.
          if (cnt_q == 4'd1) begin
            result_q <= sh_d;
            zero_q   <= (sh_d == '0);
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Result   = result_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;
  assign Illegal  = ill_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec: hand-computed vectors checked with immediate assertions.
module tb_alu_seq_exec;

  logic        Clock;
  logic        Reset_n;
  logic        Start;
  logic [3:0]  Operacioni;
  logic [15:0] A;
  logic [15:0] B;
  logic        Busy;
  logic        Done;
  logic [15:0] Result;
  logic        Zero;
  logic        Overflow;
  logic        Illegal;

  int n_assert = 0;
  int n_fail   = 0;

  alu_seq_exec #(.WIDTH(16)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Operacioni (Operacioni),
    .A          (A),
    .B          (B),
    .Busy       (Busy),
    .Done       (Done),
    .Result     (Result),
    .Zero       (Zero),
    .Overflow   (Overflow),
    .Illegal    (Illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Present an op for exactly one edge, then drop Start.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    Start      = 1'b1;
    Operacioni = op;
    A          = a;
    B          = b;
    tick();
    Start = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic done, input logic busy,
                         input logic [15:0] res, input logic z, input logic ov, input logic il);
    chk1 ({tag, ".Done"},     Done,     done);
    chk1 ({tag, ".Busy"},     Busy,     busy);
    chk16({tag, ".Result"},   Result,   res);
    chk1 ({tag, ".Zero"},     Zero,     z);
    chk1 ({tag, ".Overflow"}, Overflow, ov);
    chk1 ({tag, ".Illegal"},  Illegal,  il);
  endtask

  initial begin
    Reset_n    = 1'b0;
    Start      = 1'b0;
    Operacioni = 4'b0000;
    A          = 16'h0000;
    B          = 16'h0000;
    tick();
    tick();
    chk_out("reset", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Reset wins over a coincident Start.
    Start = 1'b1; Operacioni = 4'b0100; A = 16'h0001; B = 16'h0001;
    tick();
    chk_out("rst_vs_start", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    Start   = 1'b0;
    Reset_n = 1'b1;
    tick();

    issue(4'b0100, 16'h7FFF, 16'h0001);
    chk_out("add_ovf", 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("add_hold", 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

    issue(4'b1100, 16'h0005, 16'h0005);
    chk_out("sub_zero", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    issue(4'b1001, 16'hFFFE, 16'h0001);
    chk_out("slt_neg", 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
    issue(4'b1101, 16'h8000, 16'h0001);
    chk_out("sub_ovf", 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    issue(4'b1001, 16'h7FFF, 16'h8000);
    chk_out("slt_ovf_corr", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    issue(4'b0010, 16'h1200, 16'h0034);
    chk_out("or", 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0);

    // SLL by 15 with a foreign Start held high the whole time.
    issue(4'b0110, 16'h0001, 16'h000F);
    chk_out("sll15_acc", 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    Start = 1'b1; Operacioni = 4'b0000; A = 16'hFFFF; B = 16'h0000;
    for (int i = 1; i < 15; i++) begin
      tick();
      chk1("sll15_busy", Busy, 1'b1);
      chk1("sll15_nodone", Done, 1'b0);
    end
    tick();
    Start = 1'b0;
    chk_out("sll15_done", 1'b1, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("sll15_hold", 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0);

    issue(4'b0111, 16'h8000, 16'h0000);
    chk_out("srl0", 1'b1, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0);

    issue(4'b0111, 16'hF000, 16'h0004);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk1("srl4_busy", Busy, 1'b1);
    end
    tick();
    chk_out("srl4_done", 1'b1, 1'b0, 16'h0F00, 1'b0, 1'b0, 1'b0);

    issue(4'b0110, 16'h8000, 16'h0001);
    tick();
    chk_out("sll1_zero", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    issue(4'b0000, 16'hF0F0, 16'h0FF0);
    chk_out("b2b_and", 1'b1, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0);
    issue(4'b0011, 16'hF0F0, 16'h0FF0);
    chk_out("b2b_xor", 1'b1, 1'b0, 16'hFF00, 1'b0, 1'b0, 1'b0);

    // Abort an 8-step shift with reset on its third cycle.
    issue(4'b0110, 16'h0001, 16'h0008);
    tick();
    tick();
    Reset_n = 1'b0;
    tick();
    chk_out("abort_rst", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    Reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("abort_nodone", Done, 1'b0);
    end
    chk1("abort_idle", Busy, 1'b0);

    issue(4'b1110, 16'h1234, 16'h5678);
    chk_out("illegal", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    issue(4'b0101, 16'hFFFF, 16'h0001);
    chk_out("add_wrap", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
